display_rotator: RTL and testbench
==================================

Name: display_rotator

Overview:
Output stage between the clock/temperature display drivers and the board's 7-segment pins. It consumes the two complete display streams (time and temperature), selects one according to the 2-bit mode switches, and drives the unit-select line `cf` back to the temperature path. In rotating modes it steps through a 6-slot schedule with a programmable dwell per slot. It also blanks the display briefly on every source change so that no mixed-source digits appear.

Parameters:
- CLK_FREQ_HZ, 100_000_000, input clock frequency.
- DWELL_MS, 2000, time spent in each rotation slot.
- BLANK_CYCLES, 1024, clocks of forced blank after any change of source or `cf`; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- mode  in  2  raw switch inputs sw[15:14]; asynchronous to clk
- time_an_n  in  8  anode enables from the clock display
- time_segs_n  in  7  segments from the clock display
- time_dp_n  in  1  decimal point from the clock display
- temp_an_n  in  8  anode enables from the temperature display
- temp_segs_n  in  7  segments from the temperature display
- temp_dp_n  in  1  decimal point from the temperature display
- an_n  out  8  anode enables to the pins
- segs_n  out  7  segments to the pins
- dp_n  out  1  decimal point to the pins
- cf  out  1  temperature unit select to the temperature path; 0 = °C, 1 = °F
- slot  out  3  current rotation slot, 0..5 (debug)

Behaviour:
- Reset: one clock, `clk`; reset `rst` is asynchronous and active-low. While asserted:
  - an_n = 8'hFF, segs_n = 7'h7F, dp_n = 1
  - cf = 0, slot = 0
  - mode synchronizer = 2'b00, dwell count = 0, blank count = 0
- Mode input: passes through a 2-flop synchronizer; mode_s is the synchronized value.
- Mode change detection: mode_s differs from its previous-cycle value.
- On mode change: slot ← 0, dwell count ← 0.
- Dwell timer:
  - DWELL_CYCLES = CLK_FREQ_HZ/1000*DWELL_MS; counter width is $clog2(DWELL_CYCLES).
  - Runs only when mode_s[1] = 1.
  - On reaching DWELL_CYCLES-1: count ← 0 and slot ← (slot==5 ? 0 : slot+1).
  - When mode_s[1] = 0: dwell count and slot are held at 0.
- Simultaneous mode change and dwell expiry: the mode change wins; slot = 0 and count = 0.
- Source and cf selection (combinational, from mode_s and slot):
  - 00: TIME, cf=0
  - 01: TEMP, cf=0
  - 10: slots 0,2,4 → TIME; slots 1,3,5 → TEMP; cf=0
  - 11: slots 0,3 → TIME; slots 1,4 → TEMP with cf=0; slots 2,5 → TEMP with cf=1
- `cf` output: registered, so it changes one cycle after the slot or mode update.
- Blanking:
  - Whenever the selected {src, cf} pair differs from the previous cycle's pair, the blank counter loads BLANK_CYCLES.
  - While the counter is non-zero: it decrements each cycle and the outputs are driven to their reset (blank) values.
  - A new change during a blank reloads the counter, so blanking is extended.
- Display outputs: registered, with 1-cycle latency from the input buses to the pins when not blanking. They show the selected source's an_n/segs_n/dp_n unmodified.
- Reset mid-rotation: everything returns to reset values immediately. After deassertion, mode_s is valid 2 cycles later.
  - If that mode_s is non-zero, the resulting mode change restarts the schedule at slot 0.
  - The temperature source, or a cf change, triggers a blank.

Decomposition:
- Package `display_pkg`:
  - src_t enum {SRC_TIME, SRC_TEMP}
  - NUM_SLOTS = 6
  - AN_OFF = 8'hFF, SEGS_OFF = 7'h7F
- One sub-module, `dwell_timer`: parameterized terminal count; inputs clk, rst, en, clr; output tick (one-cycle pulse).
- Synchronizer, slot counter, selection table, blank counter and output registers remain in display_rotator.

Test Plan:
All scenarios use CLK_FREQ_HZ=1000, DWELL_MS=4 (4 cycles) and BLANK_CYCLES=2.
1. Reset with mode=00 and time_an_n=8'hFE, time_segs_n=7'h40; release reset → an_n=FF and segs_n=7F during reset; an_n=FE and segs_n=40 within 2 cycles of release; cf=0; slot stays 0.
2. mode=10, distinct constant buses per source → slot sequence 0,1,2,3,4,5,0 with a change every 4 cycles. Each TIME↔TEMP switch gives 2 blank cycles (an_n=FF), then the new source's values.
3. mode=11, run 24 cycles → cf=1 only during slots 2 and 5. The slot 1→2 transition (same source, cf change) still blanks for 2 cycles.
4. mode changed 10→01 mid-slot 3 → 2 cycles after the change, slot=0 and dwell restarts. TEMP is shown after the blank, and cf=0.
5. Mode change coinciding with dwell expiry → slot=0, not slot+1.
6. rst asserted mid-blank in mode 11 slot 2 → outputs go blank immediately and cf=0. After release, the schedule restarts at slot 0.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the display output stage
package display_pkg;
   typedef enum logic {SRC_TIME, SRC_TEMP} src_t;
   localparam int NUM_SLOTS = 6;
   localparam logic [7:0] AN_OFF = 8'hFF;
   localparam logic [6:0] SEGS_OFF = 7'h7F;
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: free-running slot timer that pulses tick on its terminal count
module dwell_timer #(
   parameter int TC = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int W = TC > 1 ? $clog2(TC) : 1;
   logic [W-1:0] cnt_q, cnt_d;
   // a clear always beats an expiry, so no tick is issued in a clear cycle
   assign tick = en && !clr && cnt_q == W'(TC - 1);
   // next count: clear, wrap at terminal count, else advance while enabled
   always_comb cnt_d = (clr || tick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
   // count register
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/display_rotator.sv
// display_rotator: selects time/temperature display stream with rotation and change blanking
module display_rotator
   import display_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = 100_000_000,
   parameter int DWELL_MS     = 2000,
   parameter int BLANK_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] mode,
   input  logic [7:0] time_an_n,
   input  logic [6:0] time_segs_n,
   input  logic       time_dp_n,
   input  logic [7:0] temp_an_n,
   input  logic [6:0] temp_segs_n,
   input  logic       temp_dp_n,
   output logic [7:0] an_n,
   output logic [6:0] segs_n,
   output logic       dp_n,
   output logic       cf,
   output logic [2:0] slot
);
   localparam int DWELL_CYCLES = CLK_FREQ_HZ / 1000 * DWELL_MS;
   localparam int BW = $clog2(BLANK_CYCLES + 1);
   logic [1:0] mode_m_q, mode_s_q, mode_p_q;
   logic [2:0] slot_q, slot_d;
   logic [BW-1:0] blank_q, blank_d;
   logic [7:0] an_q, an_d;
   logic [6:0] segs_q, segs_d;
   logic dp_q, dp_d, cf_q, cf_sel, cf_p_q, mode_chg, tick, sel_chg;
   src_t src, src_p_q;
   assign mode_chg = mode_s_q != mode_p_q;
   dwell_timer #(.TC(DWELL_CYCLES)) u_dwell (
      .clk  (clk),
      .rst  (rst),
      .en   (mode_s_q[1]),
      .clr  (mode_chg || !mode_s_q[1]),
      .tick (tick)
   );
   // source and unit selection for the current mode and rotation slot
   always_comb begin
      src = SRC_TIME;
      cf_sel = 1'b0;
      case (mode_s_q)
         2'b01: src = SRC_TEMP;
         2'b10: src = slot_q[0] ? SRC_TEMP : SRC_TIME;
         2'b11: begin
            src = (slot_q == 3'd0 || slot_q == 3'd3) ? SRC_TIME : SRC_TEMP;
            cf_sel = slot_q == 3'd2 || slot_q == 3'd5;
         end
         default: ;
      endcase
   end
   // slot stepping, blank counter and muxed pin values; a blank covers the whole switch
   always_comb begin
      slot_d = (mode_chg || !mode_s_q[1]) ? 3'd0 : tick ? (slot_q == 3'(NUM_SLOTS - 1) ? 3'd0 : slot_q + 3'd1) : slot_q;
      sel_chg = src != src_p_q || cf_sel != cf_p_q;
      blank_d = sel_chg ? BW'(BLANK_CYCLES) : blank_q != '0 ? blank_q - 1'b1 : blank_q;
      an_d = blank_d != '0 ? AN_OFF : src == SRC_TEMP ? temp_an_n : time_an_n;
      segs_d = blank_d != '0 ? SEGS_OFF : src == SRC_TEMP ? temp_segs_n : time_segs_n;
      dp_d = blank_d != '0 ? 1'b1 : src == SRC_TEMP ? temp_dp_n : time_dp_n;
   end
   // mode synchronizer, schedule state, previous selection and pin registers
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         mode_m_q <= 2'b00;
         mode_s_q <= 2'b00;
         mode_p_q <= 2'b00;
         slot_q <= 3'd0;
         blank_q <= '0;
         src_p_q <= SRC_TIME;
         cf_p_q <= 1'b0;
         cf_q <= 1'b0;
         an_q <= AN_OFF;
         segs_q <= SEGS_OFF;
         dp_q <= 1'b1;
      end else begin
         mode_m_q <= mode;
         mode_s_q <= mode_m_q;
         mode_p_q <= mode_s_q;
         slot_q <= slot_d;
         blank_q <= blank_d;
         src_p_q <= src;
         cf_p_q <= cf_sel;
         cf_q <= cf_sel;
         an_q <= an_d;
         segs_q <= segs_d;
         dp_q <= dp_d;
      end
   assign an_n = an_q;
   assign segs_n = segs_q;
   assign dp_n = dp_q;
   assign cf = cf_q;
   assign slot = slot_q;
endmodule

// File: tb/tb_display_rotator.sv
// tb_display_rotator: table-driven check of rotation, blanking and reset behaviour
module tb_display_rotator;
   localparam logic [1:0] K_T = 2'd0, K_P = 2'd1, K_B = 2'd2;
   typedef struct {
      logic       rst_n;
      logic [1:0] mode;
      logic [2:0] slot;
      logic [1:0] kind;
      logic       cf;
   } vec_t;
   vec_t tbl[$];
   logic clk = 1'b0;
   logic rst;
   logic [1:0] mode;
   logic [7:0] time_an_n, temp_an_n, an_n;
   logic [6:0] time_segs_n, temp_segs_n, segs_n;
   logic time_dp_n, temp_dp_n, dp_n, cf;
   logic [2:0] slot;
   int n_chk = 0;
   int n_fail = 0;
   display_rotator #(.CLK_FREQ_HZ(1000), .DWELL_MS(4), .BLANK_CYCLES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .mode        (mode),
      .time_an_n   (time_an_n),
      .time_segs_n (time_segs_n),
      .time_dp_n   (time_dp_n),
      .temp_an_n   (temp_an_n),
      .temp_segs_n (temp_segs_n),
      .temp_dp_n   (temp_dp_n),
      .an_n        (an_n),
      .segs_n      (segs_n),
      .dp_n        (dp_n),
      .cf          (cf),
      .slot        (slot)
   );
   always #5 clk = ~clk;
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic add(input int n, input logic r, input logic [1:0] m, input logic [2:0] s, input logic [1:0] k, input logic c);
      vec_t v;
      v.rst_n = r;
      v.mode = m;
      v.slot = s;
      v.kind = k;
      v.cf = c;
      for (int j = 0; j < n; j++) tbl.push_back(v);
   endtask
   task automatic chk_row(input int i, input vec_t v);
      logic [7:0] ea;
      logic [6:0] es;
      logic ed;
      ea = v.kind == K_T ? 8'hFE : v.kind == K_P ? 8'hF7 : 8'hFF;
      es = v.kind == K_T ? 7'h40 : v.kind == K_P ? 7'h12 : 7'h7F;
      ed = v.kind == K_P ? 1'b0 : 1'b1;
      chk($sformatf("row%0d an_n", i), an_n, ea);
      chk($sformatf("row%0d segs_n", i), {1'b0, segs_n}, {1'b0, es});
      chk($sformatf("row%0d dp_n", i), {7'b0, dp_n}, {7'b0, ed});
      chk($sformatf("row%0d cf", i), {7'b0, cf}, {7'b0, v.cf});
      chk($sformatf("row%0d slot", i), {5'b0, slot}, {5'b0, v.slot});
   endtask
   initial begin
      rst = 1'b0;
      mode = 2'b00;
      time_an_n = 8'hFE;
      time_segs_n = 7'h40;
      time_dp_n = 1'b1;
      temp_an_n = 8'hF7;
      temp_segs_n = 7'h12;
      temp_dp_n = 1'b0;
      // reset then mode 00: time stream shown, no rotation
      add(2, 0, 2'b00, 0, K_B, 0); add(4, 1, 2'b00, 0, K_T, 0);
      // mode 10: alternate every 4 cycles, 2 blank cycles per switch
      add(2, 0, 2'b10, 0, K_B, 0); add(6, 1, 2'b10, 0, K_T, 0);
      add(1, 1, 2'b10, 1, K_T, 0); add(2, 1, 2'b10, 1, K_B, 0); add(1, 1, 2'b10, 1, K_P, 0);
      add(1, 1, 2'b10, 2, K_P, 0); add(2, 1, 2'b10, 2, K_B, 0); add(1, 1, 2'b10, 2, K_T, 0);
      add(1, 1, 2'b10, 3, K_T, 0); add(2, 1, 2'b10, 3, K_B, 0); add(1, 1, 2'b10, 3, K_P, 0);
      add(1, 1, 2'b10, 4, K_P, 0); add(2, 1, 2'b10, 4, K_B, 0); add(1, 1, 2'b10, 4, K_T, 0);
      add(1, 1, 2'b10, 5, K_T, 0); add(2, 1, 2'b10, 5, K_B, 0); add(1, 1, 2'b10, 5, K_P, 0);
      add(1, 1, 2'b10, 0, K_P, 0);
      // mode 11: fahrenheit in slots 2 and 5, cf-only change also blanks
      add(2, 0, 2'b11, 0, K_B, 0); add(6, 1, 2'b11, 0, K_T, 0);
      add(1, 1, 2'b11, 1, K_T, 0); add(2, 1, 2'b11, 1, K_B, 0); add(1, 1, 2'b11, 1, K_P, 0);
      add(1, 1, 2'b11, 2, K_P, 0); add(2, 1, 2'b11, 2, K_B, 1); add(1, 1, 2'b11, 2, K_P, 1);
      add(1, 1, 2'b11, 3, K_P, 1); add(2, 1, 2'b11, 3, K_B, 0); add(1, 1, 2'b11, 3, K_T, 0);
      add(1, 1, 2'b11, 4, K_T, 0); add(2, 1, 2'b11, 4, K_B, 0); add(1, 1, 2'b11, 4, K_P, 0);
      add(1, 1, 2'b11, 5, K_P, 0); add(2, 1, 2'b11, 5, K_B, 1); add(1, 1, 2'b11, 5, K_P, 1);
      add(1, 1, 2'b11, 0, K_P, 1); add(1, 1, 2'b11, 0, K_B, 0);
      // mode 10 -> 01 during slot 3: slot returns to 0, temperature shown
      add(2, 0, 2'b10, 0, K_B, 0); add(6, 1, 2'b10, 0, K_T, 0);
      add(1, 1, 2'b10, 1, K_T, 0); add(2, 1, 2'b10, 1, K_B, 0); add(1, 1, 2'b10, 1, K_P, 0);
      add(1, 1, 2'b10, 2, K_P, 0); add(2, 1, 2'b10, 2, K_B, 0); add(1, 1, 2'b10, 2, K_T, 0);
      add(1, 1, 2'b10, 3, K_T, 0); add(1, 1, 2'b10, 3, K_B, 0);
      add(1, 1, 2'b01, 3, K_B, 0); add(1, 1, 2'b01, 3, K_P, 0); add(4, 1, 2'b01, 0, K_P, 0);
      // mode change lands on the dwell expiry cycle: slot stays 0
      add(2, 0, 2'b10, 0, K_B, 0); add(4, 1, 2'b10, 0, K_T, 0); add(6, 1, 2'b11, 0, K_T, 0);
      add(1, 1, 2'b11, 1, K_T, 0); add(1, 1, 2'b11, 1, K_B, 0);
      foreach (tbl[i]) begin
         rst = tbl[i].rst_n;
         mode = tbl[i].mode;
         step;
         chk_row(i, tbl[i]);
      end
      // reset asserted mid-blank in mode 11 slot 2
      rst = 1'b0;
      mode = 2'b11;
      step;
      step;
      rst = 1'b1;
      repeat (12) step;
      chk("pre-reset slot", {5'b0, slot}, 8'd2);
      chk("pre-reset an_n", an_n, 8'hFF);
      chk("pre-reset cf", {7'b0, cf}, 8'd1);
      rst = 1'b0;
      #1;
      chk("async an_n", an_n, 8'hFF);
      chk("async segs_n", {1'b0, segs_n}, 8'h7F);
      chk("async dp_n", {7'b0, dp_n}, 8'd1);
      chk("async cf", {7'b0, cf}, 8'd0);
      chk("async slot", {5'b0, slot}, 8'd0);
      step;
      rst = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         step;
         chk($sformatf("restart%0d slot", i), {5'b0, slot}, i == 7 ? 8'd1 : 8'd0);
         chk($sformatf("restart%0d an_n", i), an_n, 8'hFE);
         chk($sformatf("restart%0d cf", i), {7'b0, cf}, 8'd0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
